seeded_sqrt: RTL and testbench

SEEDED_SQRT -- requirements
Module: seeded_sqrt

---
 rtl/seeded_sqrt.sv | 119 +++++++++++
 tb/tb_seeded_sqrt.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seeded_sqrt.sv
// Seeded restoring square root of an unsigned Q(WIDTH-FRAC).FRAC operand.
// One result bit per cycle, starting from a bit position derived from the operand's leading-one seed.
module seeded_sqrt #(
  parameter int WIDTH = 12,
  parameter int FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] fixed_point_vector,
  input  logic [5:0]       location,
  input  logic             location_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] root,
  output logic             root_valid,
  output logic             busy
);

  localparam int RAD_W  = WIDTH + FRAC;
  localparam int ROOT_W = RAD_W / 2;
  localparam int IDX_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  localparam logic [IDX_W-1:0] TOP_BIT    = IDX_W'(ROOT_W - 1);
  localparam logic [IDX_W-1:0] NOSEED_BIT = IDX_W'(FRAC - 1);
  localparam logic [6:0]       TOP_BIT_W  = 7'(ROOT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [RAD_W-1:0]  rad_q;
  logic [ROOT_W-1:0] work_q;
  logic [ROOT_W-1:0] work_d;
  logic [ROOT_W-1:0] cand;
  logic [RAD_W-1:0]  cand_sq;
  logic [IDX_W-1:0]  bit_q;
  logic [IDX_W-1:0]  start_bit;
  logic [6:0]        seed_sum;
  logic [WIDTH-1:0]  root_q;
  logic              root_valid_q;
  logic              busy_q;
  logic              in_ready_q;

  // Seed points at the integer root's top bit; shift it into the fractional
  // result frame and clamp so it can never index past the root width.
  assign seed_sum = {1'b0, location} + 7'(FRAC);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    start_bit = NOSEED_BIT;
    if (location_valid) begin
      start_bit = (seed_sum > TOP_BIT_W) ? TOP_BIT : IDX_W'(seed_sum);
    end
  end

  // Trial bit kept only if the full-width square still fits under the radicand.
  always_comb begin
    cand    = work_q | (ROOT_W'(1) << bit_q);
    cand_sq = RAD_W'(cand) * RAD_W'(cand);
    work_d  = (cand_sq <= rad_q) ? cand : work_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= S_IDLE;
      rad_q        <= '0;
      work_q       <= '0;
      bit_q        <= '0;
      root_q       <= '0;
      root_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      root_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            rad_q      <= {fixed_point_vector, {FRAC{1'b0}}};
            work_q     <= '0;
            bit_q      <= start_bit;
            state_q    <= S_ITER;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        S_ITER: begin
          work_q <= work_d;
          if (bit_q == '0) begin
            root_q       <= WIDTH'(work_d);
            root_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            bit_q <= bit_q - IDX_W'(1);
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign root       = root_q;
  assign root_valid = root_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seeded_sqrt.sv
// Self-checking bench for seeded_sqrt: cycle-level behavioural model compared every
// cycle, directed literal cases, reset abort, streaming random traffic and a full sweep.
module tb_seeded_sqrt;

  localparam int WIDTH  = 12;
  localparam int FRAC   = 4;
  localparam int ROOT_W = (WIDTH + FRAC) / 2;

  logic             clk = 1'b0;
  logic             rst_ = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] fpv = '0;
  logic [5:0]       location = '0;
  logic             location_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] root;
  logic             root_valid;
  logic             busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: cycles elapsed since the accepting edge, -1 when idle.
  int               m_cnt = -1;
  int               m_sb = 0;
  int               m_xfers = 0;
  int               obs_valids = 0;
  logic [WIDTH-1:0] m_root = '0;
  logic [WIDTH-1:0] m_pend = '0;

  seeded_sqrt #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk               (clk),
    .rst_              (rst_),
    .in_valid          (in_valid),
    .fixed_point_vector(fpv),
    .location          (location),
    .location_valid    (location_valid),
    .in_ready          (in_ready),
    .root              (root),
    .root_valid        (root_valid),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] model_root(input logic [WIDTH-1:0] x);
    return WIDTH'(isqrt(int'(x) * (1 << FRAC)));
  endfunction

  function automatic int model_sb(input logic [5:0] loc, input logic lv);
    if (!lv) return FRAC - 1;
    return (int'(loc) + FRAC > ROOT_W - 1) ? ROOT_W - 1 : int'(loc) + FRAC;
  endfunction

  // Reference leading-one seed: ceil(msb_index/2) of the integer part.
  function automatic logic [5:0] ref_loc(input logic [WIDTH-1:0] x);
    int ip = int'(x) >> FRAC;
    int msb = 0;
    for (int i = 0; i < WIDTH - FRAC; i++) if (ip[i]) msb = i;
    return 6'((msb + 1) / 2);
  endfunction

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      if (m_cnt >= 0) m_xfers--;
      m_cnt  = -1;
      m_root = '0;
    end else if (m_cnt >= 0) begin
      m_cnt++;
      if (m_cnt == m_sb + 1) m_root = m_pend;
      if (m_cnt == m_sb + 2) m_cnt = -1;
    end else if (in_valid) begin
      m_cnt  = 0;
      m_sb   = model_sb(location, location_valid);
      m_pend = model_root(fpv);
      m_xfers++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(m_cnt < 0));
      check("busy", 32'(busy), 32'(m_cnt >= 0));
      check("root_valid", 32'(root_valid), 32'(m_cnt >= 0 && m_cnt == m_sb + 1));
      check("root", 32'(root), 32'(m_root));
      if (root_valid) obs_valids++;
    end
  end

  // Called #1 after a rising edge; optionally scrambles inputs while busy.
  task automatic wait_ready(input bit junk);
    int k;
    for (k = 0; k < 100; k++) begin
      if (in_ready) break;
      if (junk) begin
        fpv            = WIDTH'($urandom);
        location       = 6'($urandom);
        location_valid = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    if (k == 100) check("ready_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_op(input logic [WIDTH-1:0] x, input logic [5:0] loc, input logic lv,
                       input int exp_edges, input logic [WIDTH-1:0] exp_root, input string name);
    int n;
    wait_ready(1'b0);
    fpv = x; location = loc; location_valid = lv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (root_valid) break;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_edges));
    check({name, "_root"}, 32'(root), 32'(exp_root));
  endtask

  task automatic stream_op(input logic [WIDTH-1:0] x, input int extra);
    int l;
    wait_ready(1'b1);
    l = int'(ref_loc(x)) + extra;
    fpv            = x;
    location_valid = ((x >> FRAC) != 0);
    location       = location_valid ? 6'((l > 63) ? 63 : l) : 6'($urandom);
    in_valid       = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2 rst_ = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_root_valid", 32'(root_valid), 32'(0));
    check("rst_root", 32'(root), 32'(0));

    check("pin_model_25", 32'(model_root(12'h190)), 32'h050);
    check("pin_model_quarter", 32'(model_root(12'h004)), 32'h008);
    check("pin_model_max", 32'(model_root(12'hFFF)), 32'h0FF);
    check("pin_sb_seed", 32'(model_sb(6'd2, 1'b1)), 32'(6));
    check("pin_sb_clamp", 32'(model_sb(6'd4, 1'b1)), 32'(7));
    check("pin_sb_noseed", 32'(model_sb(6'd9, 1'b0)), 32'(3));
    check("pin_refloc", 32'(ref_loc(12'hFFF)), 32'(4));

    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ = 1'b1;

    do_op(12'h190, 6'd2, 1'b1, 7, 12'h050, "sqrt25");
    do_op(12'h004, 6'd0, 1'b0, 4, 12'h008, "quarter");
    do_op(12'h000, 6'd0, 1'b0, 4, 12'h000, "zero");
    do_op(12'hFFF, 6'd4, 1'b1, 8, 12'h0FF, "clamp");
    do_op(12'h190, 6'd5, 1'b1, 8, 12'h050, "overest");

    // Abort in the third ITER cycle.
    wait_ready(1'b0);
    fpv = 12'h190; location = 6'd2; location_valid = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ = 1'b0;
    #1;
    check("abort_root", 32'(root), 32'(0));
    check("abort_root_valid", 32'(root_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    rst_ = 1'b1;
    do_op(12'h190, 6'd2, 1'b1, 7, 12'h050, "after_abort");
    do_op(12'h2A7, 6'd3, 1'b1, 8, model_root(12'h2A7), "after_abort2");

    // Streaming with in_valid held high and seeds sometimes over-estimated.
    for (int i = 0; i < 300; i++) begin
      stream_op(WIDTH'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Exhaustive operand sweep.
    for (int x = 0; x < (1 << WIDTH); x++) begin
      stream_op(WIDTH'(x), 0);
    end

    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("result_count", 32'(obs_valids), 32'(m_xfers));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
